// File: rtl/pu_msp430_reset_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pu_msp430_reset_sequencer_if                               |
// | Description : Bundle between a reset sequencer and the logic that        |
// |               consumes its resets.                                       |
// |               sw_rst    : synchronous software reset request (level)     |
// |               rst_s     : sequenced active-high resets, bit 0 first      |
// |               rst_done  : all rst_s released                             |
// |               rst_cause : 0 = last reset from rst_an, 1 = from sw_rst    |
// |               master modport: requester/consumer side                    |
// |               slave modport : sequencer side                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface pu_msp430_reset_sequencer_if #(
    parameter int NUM_RST = 3
);
    logic               sw_rst;
    logic [NUM_RST-1:0] rst_s;
    logic               rst_done;
    logic               rst_cause;

    modport master (
        output sw_rst,
        input  rst_s,
        input  rst_done,
        input  rst_cause
    );

    modport slave (
        input  sw_rst,
        output rst_s,
        output rst_done,
        output rst_cause
    );
endinterface
`default_nettype wire

// File: rtl/pu_msp430_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pu_msp430_reset_sequencer                                  |
// | Description : Per-clock-domain reset sequencer. rst_an asserts every     |
// |               output asynchronously; its release is synchronised through |
// |               SYNC_STAGES flops, rst_s[0] is stretched for               |
// |               STRETCH_CYCLES edges, then the remaining outputs release   |
// |               one at a time in index order, STEP_CYCLES edges apart.     |
// |               A level sw_rst request (ignored while still in HOLD)       |
// |               re-runs the stretch/step sequence.                         |
// | Ports       : clk    - domain clock                                      |
// |               rst_an - asynchronous reset, active low                    |
// |               bus    - slave modport: sw_rst in; rst_s, rst_done,        |
// |                        rst_cause out (all outputs straight from flops)   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pu_msp430_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int NUM_RST        = 3,
    parameter int STRETCH_CYCLES = 16,
    parameter int STEP_CYCLES    = 4
) (
    input  logic                              clk,
    input  logic                              rst_an,
    pu_msp430_reset_sequencer_if.slave        bus
);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("pu_msp430_reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (NUM_RST < 1) begin : g_bad_num_rst
        $error("pu_msp430_reset_sequencer: NUM_RST must be >= 1");
    end
    if (STRETCH_CYCLES < 1) begin : g_bad_stretch
        $error("pu_msp430_reset_sequencer: STRETCH_CYCLES must be >= 1");
    end
    if (STEP_CYCLES < 1) begin : g_bad_step
        $error("pu_msp430_reset_sequencer: STEP_CYCLES must be >= 1");
    end

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_cnt_max = (STRETCH_CYCLES > STEP_CYCLES) ? STRETCH_CYCLES : STEP_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_idx_w   = $clog2(NUM_RST + 1);

    localparam logic [c_cnt_w-1:0] c_stretch  = c_cnt_w'(STRETCH_CYCLES);
    localparam logic [c_cnt_w-1:0] c_step     = c_cnt_w'(STEP_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_RST - 1);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_STRETCH = 3'd1,
        S_STEP    = 3'd2,
        S_FIN     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_idx_w-1:0]     r_idx;
    logic [NUM_RST-1:0]     r_rst_s;
    logic                   r_done;
    logic                   r_cause;

    logic                   w_rst_int;
    logic [c_cnt_w-1:0]     w_cnt_inc;
    logic                   w_sw_take;

    assign w_rst_int = r_sync[SYNC_STAGES-1];
    assign w_cnt_inc = r_cnt + c_cnt_one;

    // A software request only counts once the synchronised release has been
    // seen; during HOLD the power-on sequence owns the outputs.
    assign w_sw_take = bus.sw_rst && (r_state != S_HOLD);

    // ------------------------------------------------------------------
    // Synchroniser and sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            r_sync  <= '1;
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_s <= '1;
            r_done  <= 1'b0;
            r_cause <= 1'b0;
        end else begin
            // The chain runs independently of sw_rst.
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};

            if (w_sw_take) begin
                // Counter is pinned at 0 for as long as the request stays
                // high, so counting starts on the first edge that samples
                // sw_rst low.
                r_rst_s <= '1;
                r_done  <= 1'b0;
                r_cause <= 1'b1;
                r_cnt   <= '0;
                r_idx   <= '0;
                r_state <= S_STRETCH;
            end else begin
                case (r_state)
                    // HOLD shares the stretch counting: r_cnt is always 0 in
                    // HOLD, so the edge that sees rst_int low is stretch
                    // count 1 (and releases at once when STRETCH_CYCLES = 1).
                    S_HOLD, S_STRETCH: begin
                        if ((r_state == S_STRETCH) || !w_rst_int) begin
                            if (w_cnt_inc == c_stretch) begin
                                r_rst_s[0] <= 1'b0;
                                r_cnt      <= '0;
                                r_idx      <= c_idx_one;
                                r_state    <= (NUM_RST > 1) ? S_STEP : S_FIN;
                            end else begin
                                r_cnt   <= w_cnt_inc;
                                r_state <= S_STRETCH;
                            end
                        end
                    end

                    S_STEP: begin
                        if (w_cnt_inc == c_step) begin
                            for (int k = 0; k < NUM_RST; k++) begin
                                if (c_idx_w'(k) == r_idx) begin
                                    r_rst_s[k] <= 1'b0;
                                end
                            end
                            r_cnt <= '0;
                            r_idx <= r_idx + c_idx_one;
                            if (r_idx == c_idx_last) begin
                                r_state <= S_FIN;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end

                    S_FIN: begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end

                    S_DONE: begin
                        r_state <= S_DONE;
                    end

                    default: begin
                        // Unreachable encodings fall back to a safe restart.
                        r_rst_s <= '1;
                        r_done  <= 1'b0;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= S_HOLD;
                    end
                endcase
            end
        end
    end

    assign bus.rst_s     = r_rst_s;
    assign bus.rst_done  = r_done;
    assign bus.rst_cause = r_cause;

    // ------------------------------------------------------------------
    // Invariants: strict release order, and done only when all released
    // ------------------------------------------------------------------
    for (genvar k = 1; k < NUM_RST; k++) begin : g_order
        a_order : assert property (@(posedge clk) disable iff (!rst_an)
            (!r_rst_s[k] |-> !r_rst_s[k-1]));
    end

    a_done_clean : assert property (@(posedge clk) disable iff (!rst_an)
        (r_done |-> (r_rst_s == '0)));

endmodule
`default_nettype wire

// File: tb/tb_pu_msp430_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pu_msp430_reset_sequencer                               |
// | Description : Bench for three sequencer configurations sharing a clock:  |
// |               d0 defaults (S=2,N=3,STR=16,STEP=4),                       |
// |               d1 (S=3,N=1,STR=1,STEP=4), d2 (S=2,N=4,STR=16,STEP=1).     |
// |               Reference model counts qualifying edges since the last     |
// |               reset event and derives each release from arithmetic.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pu_msp430_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_an_v;
    logic [2:0] sw_v;

    int checks   = 0;
    int failures = 0;

    pu_msp430_reset_sequencer_if #(.NUM_RST(3)) bus0 ();
    pu_msp430_reset_sequencer_if #(.NUM_RST(1)) bus1 ();
    pu_msp430_reset_sequencer_if #(.NUM_RST(4)) bus2 ();

    assign bus0.sw_rst = sw_v[0];
    assign bus1.sw_rst = sw_v[1];
    assign bus2.sw_rst = sw_v[2];

    pu_msp430_reset_sequencer #(
        .SYNC_STAGES(2), .NUM_RST(3), .STRETCH_CYCLES(16), .STEP_CYCLES(4)
    ) dut0 (.clk(clk), .rst_an(rst_an_v[0]), .bus(bus0));

    pu_msp430_reset_sequencer #(
        .SYNC_STAGES(3), .NUM_RST(1), .STRETCH_CYCLES(1), .STEP_CYCLES(4)
    ) dut1 (.clk(clk), .rst_an(rst_an_v[1]), .bus(bus1));

    pu_msp430_reset_sequencer #(
        .SYNC_STAGES(2), .NUM_RST(4), .STRETCH_CYCLES(16), .STEP_CYCLES(1)
    ) dut2 (.clk(clk), .rst_an(rst_an_v[2]), .bus(bus2));

    // ---------------- configuration lookup ----------------
    function automatic int p_sync(input int d);
        return (d == 1) ? 3 : 2;
    endfunction
    function automatic int p_num(input int d);
        return (d == 0) ? 3 : ((d == 1) ? 1 : 4);
    endfunction
    function automatic int p_stretch(input int d);
        return (d == 1) ? 1 : 16;
    endfunction
    function automatic int p_step(input int d);
        return (d == 2) ? 1 : 4;
    endfunction
    function automatic logic [3:0] p_mask(input int d);
        logic [3:0] m;
        m = '0;
        for (int k = 0; k < p_num(d); k++) m[k] = 1'b1;
        return m;
    endfunction

    // ---------------- DUT observation ----------------
    function automatic logic [3:0] get_s(input int d);
        if (d == 0) return {1'b0, bus0.rst_s};
        if (d == 1) return {3'b000, bus1.rst_s};
        return bus2.rst_s;
    endfunction
    function automatic logic get_done(input int d);
        return (d == 0) ? bus0.rst_done : ((d == 1) ? bus1.rst_done : bus2.rst_done);
    endfunction
    function automatic logic get_cause(input int d);
        return (d == 0) ? bus0.rst_cause : ((d == 1) ? bus1.rst_cause : bus2.rst_cause);
    endfunction

    // ---------------- reference model ----------------
    // n_edge: edges since rst_an rose (power-on mode) or edges sampling
    // sw_rst low since the last honoured request (software mode).
    int n_edge [3];
    bit sw_mode [3];

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_an_v[d]) begin
                n_edge[d]  <= 0;
                sw_mode[d] <= 1'b0;
            end else if (sw_v[d] && (sw_mode[d] || n_edge[d] > p_sync(d))) begin
                // Still waiting for the synchronised release (edges up to
                // SYNC_STAGES+1 in power-on mode) means the request is ignored.
                n_edge[d]  <= 0;
                sw_mode[d] <= 1'b1;
            end else if (n_edge[d] < 100000) begin
                n_edge[d] <= n_edge[d] + 1;
            end
        end
    end

    function automatic int m_base(input int d);
        return sw_mode[d] ? p_stretch(d) : (p_sync(d) + p_stretch(d));
    endfunction
    function automatic logic [3:0] exp_s(input int d);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < p_num(d); k++)
            r[k] = !(rst_an_v[d] && (n_edge[d] >= m_base(d) + k * p_step(d)));
        return r;
    endfunction
    function automatic logic exp_done(input int d);
        return rst_an_v[d] && (n_edge[d] >= m_base(d) + (p_num(d) - 1) * p_step(d) + 1);
    endfunction
    function automatic logic exp_cause(input int d);
        return rst_an_v[d] && sw_mode[d];
    endfunction

    // ---------------- recorded release edges ----------------
    int fall_at [3][4];
    int done_at [3];

    int want_po_fall [3][4] = '{'{18, 22, 26, -1}, '{4, -1, -1, -1}, '{18, 19, 20, 21}};
    int want_po_done [3]    = '{27, 5, 22};
    int want_sw_fall [3][4] = '{'{16, 20, 24, -1}, '{1, -1, -1, -1}, '{16, 17, 18, 19}};
    int want_sw_done [3]    = '{25, 2, 20};

    // Runs n_edges edges after the caller's stimulus change, comparing every
    // cycle with the model and recording when each output fell. sw_v is
    // dropped after edge sw_edges (0 = leave as is).
    task automatic run_and_record(input int n_edges, input int sw_edges);
        logic [3:0] obs;
        for (int d = 0; d < 3; d++) begin
            done_at[d] = -1;
            for (int k = 0; k < 4; k++) fall_at[d][k] = -1;
        end
        for (int e = 1; e <= n_edges; e++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                obs = get_s(d);
                checks++;
                if (obs !== exp_s(d) || get_done(d) !== exp_done(d) || get_cause(d) !== exp_cause(d)) begin
                    failures++;
                    $display("FAIL seq_model d%0d edge %0d: rst_s=%b done=%b cause=%b, expected rst_s=%b done=%b cause=%b",
                             d, e, obs, get_done(d), get_cause(d), exp_s(d), exp_done(d), exp_cause(d));
                end
                for (int k = 0; k < p_num(d); k++)
                    if (obs[k] === 1'b0 && fall_at[d][k] < 0) fall_at[d][k] = e;
                if (get_done(d) === 1'b1 && done_at[d] < 0) done_at[d] = e;
            end
            if (e == sw_edges) sw_v = '0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_an_v = '0;
        sw_v     = '0;
        repeat (5) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (get_s(d) !== p_mask(d) || get_done(d) !== 1'b0 || get_cause(d) !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_state d%0d: rst_s=%b done=%b cause=%b, expected rst_s=%b done=0 cause=0",
                             d, get_s(d), get_done(d), get_cause(d), p_mask(d));
                end
            end
        end
    endtask

    task automatic test_power_on(input bit sw_in_hold);
        rst_an_v = '0;
        sw_v     = '0;
        repeat (5) @(negedge clk);
        rst_an_v = '1;
        sw_v     = sw_in_hold ? 3'b111 : 3'b000;
        run_and_record(32, sw_in_hold ? 3 : 0);
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < p_num(d); k++) begin
                checks++;
                if (fall_at[d][k] !== want_po_fall[d][k]) begin
                    failures++;
                    $display("FAIL power_on_release hold_sw=%0d d%0d bit%0d: fell at edge %0d, expected edge %0d",
                             sw_in_hold, d, k, fall_at[d][k], want_po_fall[d][k]);
                end
            end
            checks++;
            if (done_at[d] !== want_po_done[d] || get_cause(d) !== 1'b0) begin
                failures++;
                $display("FAIL power_on_done hold_sw=%0d d%0d: done at edge %0d cause=%b, expected edge %0d cause=0",
                         sw_in_hold, d, done_at[d], get_cause(d), want_po_done[d]);
            end
        end
    endtask

    task automatic test_sw_in_done();
        sw_v = 3'b111;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (get_s(d) !== p_mask(d) || get_done(d) !== 1'b0 || get_cause(d) !== 1'b1) begin
                    failures++;
                    $display("FAIL sw_assert d%0d cycle %0d: rst_s=%b done=%b cause=%b, expected rst_s=%b done=0 cause=1",
                             d, c, get_s(d), get_done(d), get_cause(d), p_mask(d));
                end
            end
        end
        sw_v = '0;
        run_and_record(30, 0);
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < p_num(d); k++) begin
                checks++;
                if (fall_at[d][k] !== want_sw_fall[d][k]) begin
                    failures++;
                    $display("FAIL sw_release d%0d bit%0d: fell at edge %0d, expected edge %0d",
                             d, k, fall_at[d][k], want_sw_fall[d][k]);
                end
            end
            checks++;
            if (done_at[d] !== want_sw_done[d] || get_cause(d) !== 1'b1) begin
                failures++;
                $display("FAIL sw_done d%0d: done at edge %0d cause=%b, expected edge %0d cause=1",
                         d, done_at[d], get_cause(d), want_sw_done[d]);
            end
        end
    endtask

    task automatic test_async_abort();
        rst_an_v = '0;
        sw_v     = '0;
        repeat (2) @(negedge clk);
        rst_an_v = '1;
        run_and_record(20, 0);
        // Mid-cycle assertion: the next clock edge is still 3 time units away.
        #2;
        rst_an_v = '0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (get_s(d) !== p_mask(d) || get_done(d) !== 1'b0 || get_cause(d) !== 1'b0) begin
                failures++;
                $display("FAIL async_abort d%0d: rst_s=%b done=%b cause=%b, expected rst_s=%b done=0 cause=0",
                         d, get_s(d), get_done(d), get_cause(d), p_mask(d));
            end
        end
        @(negedge clk);
        rst_an_v = '1;
        run_and_record(32, 0);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (fall_at[d][0] !== want_po_fall[d][0] || done_at[d] !== want_po_done[d]) begin
                failures++;
                $display("FAIL abort_restart d%0d: bit0 at edge %0d done at %0d, expected %0d and %0d",
                         d, fall_at[d][0], done_at[d], want_po_fall[d][0], want_po_done[d]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] obs;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                obs = get_s(d);
                checks++;
                if (obs !== exp_s(d) || get_done(d) !== exp_done(d) || get_cause(d) !== exp_cause(d)) begin
                    failures++;
                    $display("FAIL random_model d%0d cycle %0d: rst_s=%b done=%b cause=%b, expected rst_s=%b done=%b cause=%b",
                             d, c, obs, get_done(d), get_cause(d), exp_s(d), exp_done(d), exp_cause(d));
                end
                for (int k = 1; k < p_num(d); k++) begin
                    checks++;
                    if (obs[k] === 1'b0 && obs[k-1] !== 1'b0) begin
                        failures++;
                        $display("FAIL random_order d%0d cycle %0d: rst_s=%b has bit%0d released before bit%0d",
                                 d, c, obs, k, k - 1);
                    end
                end
                sw_v[d] = ($urandom_range(0, 99) < 3);
                if (!rst_an_v[d]) rst_an_v[d] = ($urandom_range(0, 2) == 0);
                else if ($urandom_range(0, 199) == 0) rst_an_v[d] = 1'b0;
            end
        end
    endtask

    initial begin
        rst_an_v = '0;
        sw_v     = '0;
        test_reset();
        test_power_on(1'b0);
        test_sw_in_done();
        test_power_on(1'b1);
        test_async_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
